soc_design_pio_bank: RTL

SOC_DESIGN_PIO_BANK -- requirements
Module: soc_design_pio_bank

---
 rtl/soc_design_pio_pkg.sv | 25 ++
 rtl/soc_design_pio_bank_if.sv | 24 ++
 rtl/soc_design_pio_sync_edge.sv | 56 +++++
 rtl/soc_design_pio_bank.sv | 121 ++++++++++++
 4 files changed

// File: rtl/soc_design_pio_pkg.sv
// Shared constants for the PIO bank: per-channel register offsets, edge modes
// and the address-width helper used by both the interface and the top level.
package soc_design_pio_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [2:0] OFF_DATA    = 3'd0;
    localparam logic [2:0] OFF_IN      = 3'd1;
    localparam logic [2:0] OFF_OUTSET  = 3'd2;
    localparam logic [2:0] OFF_OUTCLR  = 3'd3;
    localparam logic [2:0] OFF_EDGECAP = 3'd4;
    localparam logic [2:0] OFF_IRQMASK = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Word address = {channel, 3-bit offset}; channel field is at least one bit.
    function automatic int unsigned pio_addr_w(input int unsigned num_ch);
        int unsigned ch_w;
        ch_w = (num_ch > 1) ? unsigned'($clog2(num_ch)) : 1;
        return ch_w + 3;
    endfunction

endpackage

// File: rtl/soc_design_pio_bank_if.sv
// Avalon-MM slave bus of the PIO bank; address width follows the channel count.
interface soc_design_pio_bank_if #(
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned ADDR_W = soc_design_pio_pkg::pio_addr_w(NUM_CH);

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );

endinterface

// File: rtl/soc_design_pio_sync_edge.sv
// Per-channel input path: 2-flop synchronizer, a third history flop and the
// edge detector between stages two and three.
module soc_design_pio_sync_edge
    import soc_design_pio_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned EDGE_MODE = EDGE_RISING
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] in_sync,
    output logic [DATA_W-1:0] edge_c
);

    logic [DATA_W-1:0] s1_q, s1_d;
    logic [DATA_W-1:0] s2_q, s2_d;
    logic [DATA_W-1:0] s3_q, s3_d;
    logic              armed_q, armed_d;

    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        s3_d    = s2_q;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            armed_q <= armed_d;
        end
    end

    // Edges are masked for the first cycle after reset while the pipeline refills.
    always_comb begin
        edge_c = '0;
        if (armed_q) begin
            case (EDGE_MODE)
                EDGE_FALLING: edge_c = ~s2_q & s3_q;
                EDGE_ANY:     edge_c = s2_q ^ s3_q;
                default:      edge_c = s2_q & ~s3_q;
            endcase
        end
    end

    assign in_sync = s2_q;

endmodule

// File: rtl/soc_design_pio_bank.sv
// Multi-channel PIO bank: address decode, per-channel DATA/EDGECAP/IRQMASK
// registers, registered read mux and the registered irq reduction.
module soc_design_pio_bank
    import soc_design_pio_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter logic [31:0] RESET_VAL = 32'hFFFF_FFFF,
    parameter int unsigned EDGE_MODE = EDGE_RISING
) (
    input  logic                     clk,
    input  logic                     reset,
    soc_design_pio_bank_if.slave     bus,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     irq
);

    localparam int unsigned ADDR_W = pio_addr_w(NUM_CH);
    localparam int unsigned CH_W   = ADDR_W - 3;

    logic [DATA_W-1:0] data_q    [NUM_CH];
    logic [DATA_W-1:0] data_d    [NUM_CH];
    logic [DATA_W-1:0] edgecap_q [NUM_CH];
    logic [DATA_W-1:0] edgecap_d [NUM_CH];
    logic [DATA_W-1:0] irqmask_q [NUM_CH];
    logic [DATA_W-1:0] irqmask_d [NUM_CH];
    logic [DATA_W-1:0] ecap_clr  [NUM_CH];
    logic [DATA_W-1:0] in_sync   [NUM_CH];
    logic [DATA_W-1:0] edge_c    [NUM_CH];

    logic [CH_W-1:0]   ch;
    logic [2:0]        off;
    logic              wr_c;
    logic              rd_c;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd_val;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;
    logic              unused_wd;

    assign ch        = bus.address[ADDR_W-1:3];
    assign off       = bus.address[2:0];
    assign wr_c      = bus.chipselect & ~bus.write_n;
    assign rd_c      = bus.chipselect & ~bus.read_n;
    assign wd        = bus.writedata[DATA_W-1:0];
    assign unused_wd = ^bus.writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        soc_design_pio_sync_edge #(
            .DATA_W    (DATA_W),
            .EDGE_MODE (EDGE_MODE)
        ) u_sync_edge (
            .clk     (clk),
            .reset   (reset),
            .din     (in_port[c*DATA_W +: DATA_W]),
            .in_sync (in_sync[c]),
            .edge_c  (edge_c[c])
        );
        assign out_port[c*DATA_W +: DATA_W] = data_q[c];
    end

    // Channel indices >= NUM_CH match no loop iteration, so they read 0 and
    // writes to them fall through; reads always see pre-write register values.
    always_comb begin
        irq_d  = 1'b0;
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_d[c]    = data_q[c];
            irqmask_d[c] = irqmask_q[c];
            ecap_clr[c]  = '0;
            if (wr_c && (ch == CH_W'(c))) begin
                case (off)
                    OFF_DATA:    data_d[c]    = wd;
                    OFF_OUTSET:  data_d[c]    = data_q[c] | wd;
                    OFF_OUTCLR:  data_d[c]    = data_q[c] & ~wd;
                    OFF_EDGECAP: ecap_clr[c]  = wd;
                    OFF_IRQMASK: irqmask_d[c] = wd;
                    default:     ;
                endcase
            end
            // A fresh edge overrides a W1C clear landing in the same cycle.
            edgecap_d[c] = (edgecap_q[c] & ~ecap_clr[c]) | edge_c[c];
            if (ch == CH_W'(c)) begin
                case (off)
                    OFF_DATA:    rd_val = data_q[c];
                    OFF_IN:      rd_val = in_sync[c];
                    OFF_EDGECAP: rd_val = edgecap_q[c];
                    OFF_IRQMASK: rd_val = irqmask_q[c];
                    default:     rd_val = '0;
                endcase
            end
            irq_d = irq_d | (|(edgecap_q[c] & irqmask_q[c]));
        end
        readdata_d = rd_c ? BUS_W'(rd_val) : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c]    <= DATA_W'(RESET_VAL);
                edgecap_q[c] <= '0;
                irqmask_q[c] <= '0;
            end
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c]    <= data_d[c];
                edgecap_q[c] <= edgecap_d[c];
                irqmask_q[c] <= irqmask_d[c];
            end
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule
